// File: rtl/usb_pkg.sv
// Shared USB definitions: handshake codes, IN scheduler state encoding and
// the default maximum packet size.
package usb_pkg;

   localparam logic [1:0] HS_ACK   = 2'b00;
   localparam logic [1:0] HS_NONE  = 2'b01;
   localparam logic [1:0] HS_NAK   = 2'b10;
   localparam logic [1:0] HS_STALL = 2'b11;

   localparam int unsigned MAX_PKT_DEF = 64;

   typedef enum logic [1:0] {
      IDLE,
      DECIDE,
      SEND,
      WAIT_END
   } sched_state_t;

endpackage

// File: rtl/usb_retry_buf.sv
// Single-clock MAX_PKT x 8 packet store for IN retries: synchronous write,
// asynchronous read.
module usb_retry_buf
   import usb_pkg::*;
#(
   parameter  int unsigned DEPTH = MAX_PKT_DEF,
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/usb_in_ep_scheduler.sv
// Shares the usb core IN data path between NUM_EP endpoint FIFOs: STALL/NAK/ACK
// decision, packet streaming and DATA0/1 tracking. USB_IN_RETRY_EN adds packet replay.
module usb_in_ep_scheduler
   import usb_pkg::*;
#(
   parameter int unsigned NUM_EP  = 4,
   parameter int unsigned MAX_PKT = MAX_PKT_DEF,
   parameter int unsigned CNT_W   = $clog2(MAX_PKT + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                usb_rst,
   input  logic                transaction_active,
   input  logic [3:0]          endpoint,
   input  logic                direction_in,
   input  logic                setup,
   input  logic                data_strobe,
   input  logic                success,
   output logic [1:0]          handshake,
   output logic                data_toggle,
   output logic [7:0]          data_in,
   output logic                data_in_valid,
   input  logic [NUM_EP-1:0]   ep_empty,
   input  logic [8*NUM_EP-1:0] ep_data,
   output logic [NUM_EP-1:0]   ep_rd,
   input  logic [NUM_EP-1:0]   ep_stall,
   input  logic [NUM_EP-1:0]   toggle_clr
);

   localparam int unsigned      AW      = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PKT);

   sched_state_t       state, state_d;
   logic               ta_q;
   logic               start, fall;
   logic [3:0]         cur_ep, cur_ep_d;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic               replay, replay_d;
   logic               chk, chk_d;
   logic [1:0]         hs_d;
   logic               tog_d;
   logic [7:0]         din_d;
   logic               dv_d;
   logic [NUM_EP-1:0]  toggles, toggles_d;
   logic [NUM_EP-1:0]  cur_sel;
   logic [7:0]         sel_data;
   logic               ep_ok, sel_stall, sel_empty, sel_toggle;
   logic [7:0]         replay_byte;
   logic               stop;

`ifdef USB_IN_RETRY_EN
   logic               pend, pend_d;
   logic [3:0]         pend_ep, pend_ep_d;
   logic [CNT_W-1:0]   pend_len, pend_len_d;
   logic               buf_we;
   logic [7:0]         buf_rdata;

   usb_retry_buf #(.DEPTH(MAX_PKT)) u_retry_buf (
      .clk   (clk),
      .we    (buf_we),
      .waddr (cnt[AW-1:0]),
      .wdata (data_in),
      .raddr (cnt[AW-1:0]),
      .rdata (buf_rdata)
   );

   assign replay_byte = buf_rdata;
`else
   assign replay_byte = '0;
`endif

   assign start = transaction_active & ~ta_q;
   assign fall  = ~transaction_active & ta_q;

   // One-hot decode of cur_ep; an out-of-range endpoint selects nothing.
   always_comb begin
      cur_sel  = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < NUM_EP; i++) begin
         if (32'(cur_ep) == i) begin
            cur_sel[i] = 1'b1;
            sel_data   = ep_data[8*i +: 8];
         end
      end
   end

   assign ep_ok      = |cur_sel;
   assign sel_stall  = |(ep_stall & cur_sel);
   assign sel_empty  = |(ep_empty & cur_sel);
   assign sel_toggle = |(toggles & cur_sel);

   always_comb begin
      stop = (cnt == CNT_MAX) || (!replay && sel_empty);
`ifdef USB_IN_RETRY_EN
      if (replay && cnt == pend_len) stop = 1'b1;
`endif
   end

   // The pop is combinational so the FIFO head advances by the stop-rule cycle.
   always_comb begin
      ep_rd = '0;
      if (state == SEND && !replay && data_strobe && !fall && !rst && !usb_rst)
         ep_rd = cur_sel;
   end

   always_comb begin
      state_d   = state;
      cur_ep_d  = cur_ep;
      cnt_d     = cnt;
      replay_d  = replay;
      chk_d     = 1'b0;
      hs_d      = handshake;
      tog_d     = data_toggle;
      din_d     = data_in;
      dv_d      = data_in_valid;
      toggles_d = toggles;
`ifdef USB_IN_RETRY_EN
      pend_d     = pend;
      pend_ep_d  = pend_ep;
      pend_len_d = pend_len;
      buf_we     = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (start && direction_in && !setup) begin
               cur_ep_d = endpoint;
               state_d  = DECIDE;
            end
         end
         DECIDE: begin
            tog_d   = sel_toggle;
            hs_d    = HS_NAK;
            state_d = WAIT_END;
            if (!ep_ok || sel_stall) begin
               hs_d = HS_STALL;
`ifdef USB_IN_RETRY_EN
            end else if (pend && pend_ep == cur_ep) begin
               hs_d     = HS_ACK;
               replay_d = 1'b1;
               din_d    = buf_rdata;
               dv_d     = 1'b1;
               state_d  = SEND;
            end else if (pend) begin
               hs_d = HS_NAK;
`endif
            end else if (sel_empty) begin
               hs_d = HS_NAK;
            end else begin
               hs_d     = HS_ACK;
               replay_d = 1'b0;
               din_d    = sel_data;
               dv_d     = 1'b1;
               state_d  = SEND;
            end
         end
         SEND: begin
            if (data_strobe) begin
               cnt_d = cnt + 1'b1;
               chk_d = 1'b1;
`ifdef USB_IN_RETRY_EN
               buf_we = !replay;
`endif
            end else if (chk) begin
               if (stop) begin
                  dv_d    = 1'b0;
                  state_d = WAIT_END;
               end else begin
                  din_d = replay ? replay_byte : sel_data;
               end
            end
         end
         WAIT_END: ;
         default: state_d = IDLE;
      endcase

      // End of transaction (also aborts SEND); only ACKed packets update toggles/retry.
      if (fall && state != IDLE) begin
         if (handshake == HS_ACK) begin
            if (success) begin
               toggles_d = toggles ^ cur_sel;
`ifdef USB_IN_RETRY_EN
               pend_d = 1'b0;
            end else if (cnt != '0) begin
               pend_d     = 1'b1;
               pend_ep_d  = cur_ep;
               pend_len_d = cnt;
`endif
            end
         end
         cnt_d   = '0;
         chk_d   = 1'b0;
         hs_d    = HS_NAK;
         dv_d    = 1'b0;
         state_d = IDLE;
`ifdef USB_IN_RETRY_EN
         buf_we  = 1'b0;
`endif
      end

      toggles_d = toggles_d & ~toggle_clr;
   end

   always_ff @(posedge clk) begin
      ta_q <= transaction_active;
      if (rst || usb_rst) begin
         state         <= IDLE;
         cur_ep        <= '0;
         cnt           <= '0;
         replay        <= 1'b0;
         chk           <= 1'b0;
         handshake     <= HS_NAK;
         data_toggle   <= 1'b0;
         data_in       <= '0;
         data_in_valid <= 1'b0;
         toggles       <= '0;
`ifdef USB_IN_RETRY_EN
         pend          <= 1'b0;
         pend_ep       <= '0;
         pend_len      <= '0;
`endif
      end else begin
         state         <= state_d;
         cur_ep        <= cur_ep_d;
         cnt           <= cnt_d;
         replay        <= replay_d;
         chk           <= chk_d;
         handshake     <= hs_d;
         data_toggle   <= tog_d;
         data_in       <= din_d;
         data_in_valid <= dv_d;
         toggles       <= toggles_d;
`ifdef USB_IN_RETRY_EN
         pend          <= pend_d;
         pend_ep       <= pend_ep_d;
         pend_len      <= pend_len_d;
`endif
      end
   end

endmodule

// File: tb/tb_usb_in_ep_scheduler.sv
// Scoreboard bench for usb_in_ep_scheduler with FIFO models per endpoint;
// covers both builds of USB_IN_RETRY_EN.
module tb_usb_in_ep_scheduler;

   localparam int NEP = 4;
   localparam logic [1:0] ACK   = 2'b00;
   localparam logic [1:0] NAK   = 2'b10;
   localparam logic [1:0] STALL = 2'b11;

   logic             clk = 1'b0;
   logic             rst, usb_rst, transaction_active, direction_in, setup;
   logic             data_strobe, success;
   logic [3:0]       endpoint;
   logic [1:0]       handshake;
   logic             data_toggle;
   logic [7:0]       data_in;
   logic             data_in_valid;
   logic [NEP-1:0]   ep_empty, ep_rd, ep_stall, toggle_clr;
   logic [8*NEP-1:0] ep_data;

   always #5 clk = ~clk;

   usb_in_ep_scheduler #(.NUM_EP(NEP), .MAX_PKT(64)) dut (
      .clk                (clk),
      .rst                (rst),
      .usb_rst            (usb_rst),
      .transaction_active (transaction_active),
      .endpoint           (endpoint),
      .direction_in       (direction_in),
      .setup              (setup),
      .data_strobe        (data_strobe),
      .success            (success),
      .handshake          (handshake),
      .data_toggle        (data_toggle),
      .data_in            (data_in),
      .data_in_valid      (data_in_valid),
      .ep_empty           (ep_empty),
      .ep_data            (ep_data),
      .ep_rd              (ep_rd),
      .ep_stall           (ep_stall),
      .toggle_clr         (toggle_clr)
   );

   // First-word fall-through FIFO models
   logic [7:0] fmem  [NEP][256];
   logic [7:0] fhead [NEP];
   logic [7:0] ftail [NEP];

   always @(posedge clk) begin
      for (int i = 0; i < NEP; i++) begin
         if (rst) fhead[i] <= '0;
         else if (ep_rd[i] && !ep_empty[i]) fhead[i] <= fhead[i] + 8'd1;
      end
   end

   always_comb begin
      for (int i = 0; i < NEP; i++) begin
         ep_empty[i]       = (fhead[i] == ftail[i]);
         ep_data[8*i +: 8] = fmem[i][fhead[i]];
      end
   end

   task automatic push(input int ep, input logic [7:0] b);
      fmem[ep][ftail[ep]] = b;
      ftail[ep] = ftail[ep] + 8'd1;
   endtask

   // Scoreboard queues and probe strobes
   logic [2:0] q_hs [$];
   logic [7:0] q_byte [$];
   int         q_rd [$];
   int         cur_tgt;
   logic       hs_probe, end_probe, rst_probe, done_probe;
   int         n_chk = 0;
   int         n_fail = 0;
   int         rd_tgt = 0;
   int         rd_oth = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic missing(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s: no expectation queued (t=%0t)", nm, $time);
   endtask

   always @(negedge clk) begin
      logic [2:0] e3;
      logic [7:0] eb;
      int         er;
      if (hs_probe) begin
         if (q_hs.size() == 0) missing("handshake");
         else begin
            e3 = q_hs.pop_front();
            chk("handshake", 32'(handshake), 32'(e3[2:1]));
            chk("data_toggle", 32'(data_toggle), 32'(e3[0]));
         end
         rd_tgt = 0;
         rd_oth = 0;
      end
      for (int i = 0; i < NEP; i++) begin
         if (ep_rd[i]) begin
            if (i == cur_tgt) rd_tgt++;
            else rd_oth++;
         end
      end
      if (data_strobe) begin
         chk("valid_at_strobe", 32'(data_in_valid), 32'd1);
         if (q_byte.size() == 0) missing("data_in");
         else begin
            eb = q_byte.pop_front();
            chk("data_in", 32'(data_in), 32'(eb));
         end
      end
      if (end_probe) begin
         chk("valid_after_packet", 32'(data_in_valid), 32'd0);
         if (q_rd.size() == 0) missing("ep_rd_count");
         else begin
            er = q_rd.pop_front();
            chk("ep_rd_count", 32'(rd_tgt), 32'(er));
         end
         chk("ep_rd_other_ep", 32'(rd_oth), 32'd0);
      end
      if (rst_probe) begin
         chk("rst_handshake", 32'(handshake), 32'(NAK));
         chk("rst_data_toggle", 32'(data_toggle), 32'd0);
         chk("rst_data_in", 32'(data_in), 32'd0);
         chk("rst_data_in_valid", 32'(data_in_valid), 32'd0);
         chk("rst_ep_rd", 32'(ep_rd), 32'd0);
      end
      if (done_probe)
         chk("leftover_expectations", 32'(q_hs.size() + q_byte.size() + q_rd.size()), 32'd0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_b(input logic [7:0] b);
      q_byte.push_back(b);
   endtask

   // One IN transaction: n strobes, then success on the transaction_active fall.
   task automatic do_in(input logic [3:0] ep, input logic [1:0] ehs, input logic etog,
                        input int n, input int erd, input logic succ, input logic [NEP-1:0] clr);
      q_hs.push_back({ehs, etog});
      q_rd.push_back(erd);
      tick();
      endpoint = ep; direction_in = 1'b1; setup = 1'b0; transaction_active = 1'b1;
      cur_tgt = int'(ep);
      @(posedge clk);
      tick();
      hs_probe = 1'b1;
      tick();
      hs_probe = 1'b0;
      repeat (n) begin
         data_strobe = 1'b1;
         tick();
         data_strobe = 1'b0;
         tick();
         tick();
      end
      end_probe = 1'b1;
      tick();
      end_probe = 1'b0;
      success = succ; transaction_active = 1'b0; toggle_clr = clr;
      tick();
      toggle_clr = '0; success = 1'b0; direction_in = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; usb_rst = 1'b0; transaction_active = 1'b0; direction_in = 1'b0;
      setup = 1'b0; data_strobe = 1'b0; success = 1'b0; endpoint = '0;
      ep_stall = '0; toggle_clr = '0; cur_tgt = 0;
      hs_probe = 1'b0; end_probe = 1'b0; rst_probe = 1'b0; done_probe = 1'b0;
      for (int i = 0; i < NEP; i++) ftail[i] = '0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      rst_probe = 1'b1;
      tick();
      rst_probe = 1'b0;

      // Three-byte packet on ep1
      push(1, 8'hA1); push(1, 8'hA2); push(1, 8'hA3);
      exp_b(8'hA1); exp_b(8'hA2); exp_b(8'hA3);
      do_in(4'd1, ACK, 1'b0, 3, 3, 1'b1, '0);

      // 100 bytes on ep2 -> 64 + 36, toggles 0 then 1, back to 0
      for (int i = 0; i < 100; i++) push(2, 8'(i));
      for (int i = 0; i < 64; i++) exp_b(8'(i));
      do_in(4'd2, ACK, 1'b0, 64, 64, 1'b1, '0);
      for (int i = 64; i < 100; i++) exp_b(8'(i));
      do_in(4'd2, ACK, 1'b1, 36, 36, 1'b1, '0);
      do_in(4'd2, NAK, 1'b0, 0, 0, 1'b0, '0);

      // Stall / nak decisions
      do_in(4'd5, STALL, 1'b0, 0, 0, 1'b0, '0);
      push(1, 8'hB0);
      ep_stall = 4'b0010;
      do_in(4'd1, STALL, 1'b1, 0, 0, 1'b0, '0);
      ep_stall = '0;
      do_in(4'd3, NAK, 1'b0, 0, 0, 1'b0, '0);
      exp_b(8'hB0);
      do_in(4'd1, ACK, 1'b1, 1, 1, 1'b1, '0);

      // toggle_clr coinciding with the success update of ep1
      push(1, 8'hC0);
      exp_b(8'hC0);
      do_in(4'd1, ACK, 1'b0, 1, 1, 1'b1, 4'b0010);

`ifdef USB_IN_RETRY_EN
      for (int i = 0; i < 10; i++) begin push(1, 8'hD0 + 8'(i)); exp_b(8'hD0 + 8'(i)); end
      do_in(4'd1, ACK, 1'b0, 10, 10, 1'b0, '0);
      push(2, 8'hE0);
      do_in(4'd2, NAK, 1'b0, 0, 0, 1'b0, '0);
      for (int i = 0; i < 10; i++) exp_b(8'hD0 + 8'(i));
      do_in(4'd1, ACK, 1'b0, 10, 0, 1'b1, '0);
      exp_b(8'hE0);
      do_in(4'd2, ACK, 1'b0, 1, 1, 1'b1, '0);
      do_in(4'd1, NAK, 1'b1, 0, 0, 1'b0, '0);
`else
      for (int i = 0; i < 10; i++) begin push(1, 8'hD0 + 8'(i)); exp_b(8'hD0 + 8'(i)); end
      do_in(4'd1, ACK, 1'b0, 10, 10, 1'b0, '0);
      for (int i = 0; i < 3; i++) begin push(1, 8'hF0 + 8'(i)); exp_b(8'hF0 + 8'(i)); end
      do_in(4'd1, ACK, 1'b0, 3, 3, 1'b1, '0);
      push(2, 8'hE0);
      exp_b(8'hE0);
      do_in(4'd2, ACK, 1'b0, 1, 1, 1'b1, '0);
      do_in(4'd1, NAK, 1'b1, 0, 0, 1'b0, '0);
`endif

      // usb_rst in the middle of SEND on ep3
      for (int i = 0; i < 5; i++) push(3, 8'h60 + 8'(i));
      q_hs.push_back({ACK, 1'b0});
      exp_b(8'h60);
      tick();
      endpoint = 4'd3; direction_in = 1'b1; setup = 1'b0; transaction_active = 1'b1;
      cur_tgt = 3;
      @(posedge clk);
      tick();
      hs_probe = 1'b1;
      tick();
      hs_probe = 1'b0;
      data_strobe = 1'b1;
      tick();
      data_strobe = 1'b0;
      tick();
      usb_rst = 1'b1;
      tick();
      usb_rst = 1'b0;
      rst_probe = 1'b1;
      tick();
      rst_probe = 1'b0;
      transaction_active = 1'b0; direction_in = 1'b0;
      tick();
      tick();
      do_in(4'd1, NAK, 1'b0, 0, 0, 1'b0, '0);
      do_in(4'd2, NAK, 1'b0, 0, 0, 1'b0, '0);
      for (int i = 1; i < 5; i++) exp_b(8'h60 + 8'(i));
      do_in(4'd3, ACK, 1'b0, 4, 4, 1'b1, '0);

      done_probe = 1'b1;
      tick();
      done_probe = 1'b0;
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/usb_in_ep_scheduler.md
Name: usb_in_ep_scheduler

Overview:
Shares the single IN data path of the usb core (data_in / data_in_valid / handshake / data_toggle) between NUM_EP endpoint byte sources.
On each IN token it decides STALL/NAK/ACK, streams up to MAX_PKT bytes from the addressed endpoint FIFO, and tracks per-endpoint DATA0/1 toggles.
An optional retry buffer replays a packet the host did not acknowledge.
It sits between the usb core instance and the endpoint FIFOs; the top level muxes its handshake and data_toggle onto the core when direction_in=1.

Parameters:
NUM_EP, 4, number of IN endpoints served (endpoint numbers 0..NUM_EP-1).
MAX_PKT, 64, maximum bytes per IN packet.
CNT_W, $clog2(MAX_PKT+1), byte-counter width (derived, not overridden).

Ports:
clk  in  1  48 MHz system clock, same clock as the usb core.
rst  in  1  synchronous reset, active-high.
usb_rst  in  1  bus reset seen by the usb core; same effect as rst on toggles and retry state.
transaction_active  in  1  from the usb core.
endpoint  in  4  from the usb core; valid while transaction_active=1.
direction_in  in  1  from the usb core.
setup  in  1  from the usb core.
data_strobe  in  1  from the usb core; pulses once per byte consumed.
success  in  1  from the usb core; sampled on the transaction_active fall (1 = host ACKed the IN data).
handshake  out  2  00 ack, 01 none, 10 nak, 11 stall.
data_toggle  out  1  DATA0/1 for the current endpoint.
data_in  out  8  byte presented to the usb core.
data_in_valid  out  1  1 while bytes remain in the current packet.
ep_empty  in  NUM_EP  per-endpoint FIFO empty flag (first-word fall-through FIFOs).
ep_data  in  8*NUM_EP  per-endpoint head byte; bits [8i+7:8i] belong to endpoint i.
ep_rd  out  NUM_EP  one-cycle pop pulse per endpoint.
ep_stall  in  NUM_EP  endpoint halted (driven by the EP0 request controller).
toggle_clr  in  NUM_EP  pulse that forces the endpoint's toggle to DATA0 (CLEAR_FEATURE / SET_CONFIGURATION).

Behaviour:
- Reset values (rst or usb_rst): handshake=10 (nak), data_toggle=0, data_in=0, data_in_valid=0, ep_rd=0, all toggles 0, retry pending cleared, state IDLE.
- Start condition: a rising edge of transaction_active is detected on a registered copy of transaction_active.
- IDLE: on the start condition with direction_in=1 and setup=0, latch endpoint into cur_ep and go to DECIDE. Any other transaction type is ignored and the state stays IDLE.
- DECIDE (1 cycle): handshake and data_toggle (= toggle[cur_ep]) become registered on the next edge, i.e. 2 cycles after transaction_active rises. Priority:
  1. cur_ep >= NUM_EP -> stall.
  2. ep_stall[cur_ep] -> stall.
  3. Retry pending for cur_ep -> ack, replay mode.
  4. Retry pending for another endpoint -> nak.
  5. ep_empty[cur_ep] -> nak.
  6. Otherwise -> ack, live mode.
  - stall/nak go to WAIT_END. ack goes to SEND with data_in_valid=1 and data_in = first byte, both registered with the handshake.
- SEND, per data_strobe:
  - cnt increments.
  - Live mode: ep_rd[cur_ep] pulses for exactly 1 cycle, and the byte is written to the retry buffer at index cnt.
  - data_in updates one cycle after the strobe.
- SEND, stop rules, evaluated one cycle after each strobe: data_in_valid goes to 0 and the state goes to WAIT_END when any of these holds:
  - cnt == MAX_PKT;
  - live mode and ep_empty[cur_ep]=1;
  - replay mode and cnt == stored length.
- WAIT_END: on the transaction_active fall:
  - success=1 -> toggle[cur_ep] inverts and retry pending clears.
  - success=0 -> retry pending set for cur_ep with length = cnt.
  - cnt clears, handshake returns to 10, and the state goes to IDLE.
- A transaction_active fall while in SEND is handled exactly as in WAIT_END (abort path); data_in_valid drops on the same edge.
- toggle_clr[i] forces toggle[i]=0 on any cycle. If it coincides with a success update of the same endpoint, toggle_clr wins.
- No zero-length packets: an empty endpoint always gets nak.

Optional Feature:
USB_IN_RETRY_EN
- Defined: retry buffer (MAX_PKT x 8) and pending logic are present as described in Behaviour.
- Undefined: no buffer and no pending state. On success=0 the bytes are dropped and the toggle does not invert. DECIDE priorities 3 and 4 are absent.

Decomposition:
- Shared package usb_pkg:
  - handshake constants HS_ACK=2'b00, HS_NONE=2'b01, HS_NAK=2'b10, HS_STALL=2'b11;
  - scheduler state encoding (IDLE, DECIDE, SEND, WAIT_END);
  - MAX_PKT default.
- One sub-module, usb_retry_buf: single-clock RAM of MAX_PKT x 8 with a synchronous write port and an asynchronous read port. It is instantiated only under USB_IN_RETRY_EN.

Test Plan:
1. ep1 FIFO holds 3 bytes A1 A2 A3, IN to ep1, success=1 -> ack, data_toggle=0, bytes A1 A2 A3 streamed, 3 ep_rd pulses, data_in_valid drops after the 3rd strobe, toggle[1] becomes 1.
2. ep2 FIFO holds 100 bytes, two IN to ep2 -> packets of 64 then 36 bytes, toggles 0 then 1, toggle[2]=0 at the end.
3. IN to ep5 with NUM_EP=4 -> stall. ep_stall[1]=1 -> stall. Empty ep3 -> nak. In all three cases data_in_valid stays 0 and ep_rd stays 0.
4. Retry (USB_IN_RETRY_EN): ep1 sends 10 bytes with success=0; an IN to ep2 -> nak; the next IN to ep1 -> the same 10 bytes replayed with toggle 0 and no ep_rd pulses; success=1 -> toggle[1]=1.
5. Simultaneous events: toggle_clr[1] in the same cycle as the success update for ep1 -> toggle[1]=0. usb_rst mid-SEND -> all outputs return to their reset values on the next edge.
6. Retry compiled out: the failed 10-byte packet on ep1 -> the next IN to ep1 streams fresh FIFO data and toggle[1] stays 0.
